fpu_op_dispatcher: RTL and testbench

Parametrised front end that sits between the host and the FPU arithmetic units (add/sub, CORDIC, multiplier), and extends the single-shot `begin_operation`/`ack_operation` interface to a queued one. Requests enter a tagged DEPTH-entry FIFO through a valid/ready handshake. They are issued one at a time to the selected unit using that unit's begin/ready/ack protocol. Each result returns with its tag, flags and an error bit, and a watchdog frees the pipeline if a unit never answers.

---
 rtl/fpu_op_dispatcher.sv | 208 ++++++++++++++++++++
 tb/tb_fpu_op_dispatcher.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_op_dispatcher.sv
// Queued front end for the FPU arithmetic units: a tagged request FIFO feeds a
// one-at-a-time issue FSM that runs each unit's begin/ready/ack protocol and
// returns tagged results in request order, with a watchdog for silent units.
module fpu_op_dispatcher #(
  parameter int unsigned W       = 64,
  parameter int unsigned NU      = 3,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [1:0]        req_rmode,
  input  logic [1:0]        req_region,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic [W-1:0]      req_data1,
  input  logic [W-1:0]      req_data2,
  output logic [NU-1:0]     unit_beg,
  output logic [NU-1:0]     unit_ack,
  output logic              unit_op,
  output logic [1:0]        unit_rmode,
  output logic [1:0]        unit_region,
  output logic [W-1:0]      unit_data1,
  output logic [W-1:0]      unit_data2,
  input  logic [NU-1:0]     unit_ready,
  input  logic [NU*W-1:0]   unit_result,
  input  logic [NU-1:0]     unit_ovf,
  input  logic [NU-1:0]     unit_unf,
  input  logic [NU-1:0]     unit_nan,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [TAG_W-1:0]  res_tag,
  output logic [W-1:0]      res_data,
  output logic              res_ovf,
  output logic              res_unf,
  output logic              res_nan,
  output logic              res_err,
  output logic              busy
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_BEGIN, S_WAIT, S_ACK, S_RESP} state_t;

  typedef struct packed {
    logic [2:0]       op;
    logic [1:0]       rmode;
    logic [1:0]       region;
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     data1;
    logic [W-1:0]     data2;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_nxt;
  logic            push, pop;
  entry_t          head;
  logic [1:0]      head_idx;
  logic            head_legal;

  state_t          state;
  logic [1:0]      iss_idx;
  logic [WDW-1:0]  wd;

  logic            sel_ready, sel_ovf, sel_unf, sel_nan;
  logic [W-1:0]    sel_result;

  assign push       = req_valid & req_ready;
  assign pop        = (state == S_IDLE) && (count != '0);
  assign count_nxt  = count + CW'(push) - CW'(pop);
  assign head       = mem[rd_ptr];
  assign head_idx   = head.op[2:1];
  assign head_legal = 32'(head_idx) < NU;
  assign busy       = (state != S_IDLE) || (count != '0);

  // FIFO storage; written on every accepted request
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {req_op, req_rmode, req_region, req_tag, req_data1, req_data2};
  end

  // FIFO pointers/occupancy; req_ready is registered so a same-cycle pop never frees a slot early
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      req_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count     <= count_nxt;
      req_ready <= (count_nxt != CW'(DEPTH));
    end
  end

  // Route the issued unit's ready/result/flags
  always_comb begin
    sel_ready  = 1'b0;
    sel_result = '0;
    sel_ovf    = 1'b0;
    sel_unf    = 1'b0;
    sel_nan    = 1'b0;
    for (int unsigned k = 0; k < NU; k++) begin
      if (iss_idx == 2'(k)) begin
        sel_ready  = unit_ready[k];
        sel_result = unit_result[k*W +: W];
        sel_ovf    = unit_ovf[k];
        sel_unf    = unit_unf[k];
        sel_nan    = unit_nan[k];
      end
    end
  end

  // Issue FSM with registered unit strobes, issue fields and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      iss_idx     <= '0;
      wd          <= '0;
      unit_beg    <= '0;
      unit_ack    <= '0;
      unit_op     <= 1'b0;
      unit_rmode  <= '0;
      unit_region <= '0;
      unit_data1  <= '0;
      unit_data2  <= '0;
      res_valid   <= 1'b0;
      res_tag     <= '0;
      res_data    <= '0;
      res_ovf     <= 1'b0;
      res_unf     <= 1'b0;
      res_nan     <= 1'b0;
      res_err     <= 1'b0;
    end else begin
      unit_beg <= '0;
      unit_ack <= '0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            res_tag <= head.tag;
            if (head_legal) begin
              iss_idx     <= head_idx;
              unit_op     <= head.op[0];
              unit_rmode  <= head.rmode;
              unit_region <= head.region;
              unit_data1  <= head.data1;
              unit_data2  <= head.data2;
              unit_beg    <= NU'(1) << head_idx;
              state       <= S_BEGIN;
            end else begin
              res_data  <= '0;
              res_ovf   <= 1'b0;
              res_unf   <= 1'b0;
              res_nan   <= 1'b0;
              res_err   <= 1'b1;
              res_valid <= 1'b1;
              state     <= S_RESP;
            end
          end
        end
        S_BEGIN: begin
          wd    <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // wd counts completed WAIT cycles, so the TIMEOUT-th WAIT cycle sees wd == TIMEOUT-1
          if (sel_ready) begin
            res_data <= sel_result;
            res_ovf  <= sel_ovf;
            res_unf  <= sel_unf;
            res_nan  <= sel_nan;
            res_err  <= 1'b0;
            unit_ack <= NU'(1) << iss_idx;
            state    <= S_ACK;
          end else if (wd == WDW'(TIMEOUT - 1)) begin
            res_data <= '0;
            res_ovf  <= 1'b0;
            res_unf  <= 1'b0;
            res_nan  <= 1'b0;
            res_err  <= 1'b1;
            unit_ack <= NU'(1) << iss_idx;
            state    <= S_ACK;
          end else begin
            wd <= wd + WDW'(1);
          end
        end
        S_ACK: begin
          res_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_op_dispatcher.sv
// Bench for fpu_op_dispatcher: behavioural unit models plus a request-order
// scoreboard predicting each response from the request and unit latency.
module tb_fpu_op_dispatcher;

  localparam int W = 64, NU = 3, DEPTH = 4, TAG_W = 4, TMO = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0, req_ready;
  logic [2:0]        req_op = '0;
  logic [1:0]        req_rmode = '0, req_region = '0;
  logic [TAG_W-1:0]  req_tag = '0;
  logic [W-1:0]      req_data1 = '0, req_data2 = '0;
  logic [NU-1:0]     unit_beg, unit_ack, unit_ready, unit_ovf, unit_unf, unit_nan;
  logic              unit_op;
  logic [1:0]        unit_rmode, unit_region;
  logic [W-1:0]      unit_data1, unit_data2;
  logic [NU*W-1:0]   unit_result;
  logic              res_valid, res_ready = 1'b0;
  logic [TAG_W-1:0]  res_tag;
  logic [W-1:0]      res_data;
  logic              res_ovf, res_unf, res_nan, res_err, busy;

  fpu_op_dispatcher #(.W(W), .NU(NU), .DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rmode(req_rmode), .req_region(req_region), .req_tag(req_tag),
    .req_data1(req_data1), .req_data2(req_data2),
    .unit_beg(unit_beg), .unit_ack(unit_ack), .unit_op(unit_op),
    .unit_rmode(unit_rmode), .unit_region(unit_region),
    .unit_data1(unit_data1), .unit_data2(unit_data2),
    .unit_ready(unit_ready), .unit_result(unit_result),
    .unit_ovf(unit_ovf), .unit_unf(unit_unf), .unit_nan(unit_nan),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
    .res_data(res_data), .res_ovf(res_ovf), .res_unf(res_unf),
    .res_nan(res_nan), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] oh(input int i);
    logic [63:0] v;
    v = 64'd1;
    return v << i;
  endfunction

  // ---------------- unit models ----------------
  int          lat_cfg [NU];
  logic        fix_en = 1'b0;
  logic [63:0] fix_val = '0;
  logic        act [NU];
  int          cnt [NU];
  logic [63:0] ua [NU], ub [NU];
  logic        uop [NU];

  function automatic logic [63:0] unit_fn(input int k, input logic op, input logic [63:0] a,
                                          input logic [63:0] b, input logic fe, input logic [63:0] fv);
    if (k == 0 && fe) return fv;
    return (a ^ (b << 3)) + 64'(k) * 64'h0101 + {63'b0, op};
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < NU; k++) begin
      if (rst) act[k] <= 1'b0;
      else if (unit_ack[k]) act[k] <= 1'b0;
      else if (unit_beg[k]) begin
        act[k] <= 1'b1;
        cnt[k] <= 1;
        ua[k]  <= unit_data1;
        ub[k]  <= unit_data2;
        uop[k] <= unit_op;
      end else if (act[k]) cnt[k] <= cnt[k] + 1;
    end
  end

  always_comb begin
    unit_ready  = '0;
    unit_result = '0;
    unit_ovf    = '0;
    unit_unf    = '0;
    unit_nan    = '0;
    for (int k = 0; k < NU; k++) begin
      unit_ready[k]        = act[k] && (cnt[k] >= lat_cfg[k]);
      unit_result[k*W +: W] = unit_fn(k, uop[k], ua[k], ub[k], fix_en, fix_val);
      unit_ovf[k]          = ua[k][0];
      unit_unf[k]          = ub[k][0];
      unit_nan[k]          = ua[k][1] ^ ub[k][1];
    end
  end

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [63:0]      data;
    logic [3:0]       flags;  // {ovf, unf, nan, err}
  } exp_t;
  typedef struct {
    int          idx;
    logic [63:0] d1;
  } beg_t;

  exp_t exp_q[$];
  beg_t beg_q[$];

  task automatic predict(input logic [2:0] op, input logic [TAG_W-1:0] tag,
                         input logic [63:0] d1, input logic [63:0] d2);
    exp_t e;
    beg_t b;
    int   k;
    k = int'(op[2:1]);
    e.tag = tag;
    if (k >= NU) begin
      e.data = '0; e.flags = 4'b0001;
    end else begin
      b.idx = k; b.d1 = d1;
      beg_q.push_back(b);
      if (lat_cfg[k] > TMO) begin
        e.data = '0; e.flags = 4'b0001;
      end else begin
        e.data  = unit_fn(k, op[0], d1, d2, fix_en, fix_val);
        e.flags = {d1[0], d2[0], d1[1] ^ d2[1], 1'b0};
      end
    end
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  logic        inflight = 1'b0, rdy_seen = 1'b0, ack_pend = 1'b0, prev_rv = 1'b0;
  int          in_idx = 0, beg_cyc = 0, rdy_cyc = 0, ack_cyc = 0, last_beg_cyc = 0, n_beg = 0;
  logic [63:0] in_d1 = '0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete(); beg_q.delete();
      inflight = 1'b0; rdy_seen = 1'b0; ack_pend = 1'b0; prev_rv = 1'b0;
    end else begin
      if (unit_ack != '0) begin
        if (!inflight) check("ack_unexpected", 64'(unit_ack), 64'd0);
        else begin
          check("ack_onehot", 64'(unit_ack), oh(in_idx));
          check("ack_data1_stable", unit_data1, in_d1);
          if (rdy_seen) check("ack_after_ready", 64'(cyc - rdy_cyc), 64'd1);
          else          check("ack_after_timeout", 64'(cyc - beg_cyc), 64'(TMO + 1));
        end
        inflight = 1'b0; ack_pend = 1'b1; ack_cyc = cyc;
      end else if (inflight && !rdy_seen && unit_ready[in_idx]) begin
        rdy_seen = 1'b1; rdy_cyc = cyc;
      end
      if (unit_beg != '0) begin
        n_beg++;
        if (beg_q.size() == 0) check("beg_unexpected", 64'(unit_beg), 64'd0);
        else begin
          beg_t b;
          b = beg_q.pop_front();
          check("beg_onehot", 64'(unit_beg), oh(b.idx));
          check("beg_data1", unit_data1, b.d1);
          in_idx = b.idx; in_d1 = b.d1;
        end
        inflight = 1'b1; rdy_seen = 1'b0; beg_cyc = cyc; last_beg_cyc = cyc;
      end
      if (res_valid && !prev_rv && ack_pend) begin
        check("resp_after_ack", 64'(cyc - ack_cyc), 64'd1);
        ack_pend = 1'b0;
      end
      prev_rv = res_valid;
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) check("resp_unexpected", 64'(res_tag), 64'hFFFF);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("resp_tag", 64'(res_tag), 64'(e.tag));
          check("resp_data", res_data, e.data);
          check("resp_flags", 64'({res_ovf, res_unf, res_nan, res_err}), 64'(e.flags));
        end
      end
    end
  end

  // ---------------- drivers ----------------
  int rr_mode = 1;  // 0 hold low, 1 hold high, 2 random
  initial forever begin
    @(posedge clk); #1;
    case (rr_mode)
      0:       res_ready = 1'b0;
      1:       res_ready = 1'b1;
      default: res_ready = 1'($urandom % 2);
    endcase
  end

  int acc_cyc = 0;

  task automatic push(input logic [2:0] op, input logic [TAG_W-1:0] tag, input logic [63:0] d1,
                      input logic [63:0] d2, input int budget, output bit ok);
    bit r;
    req_valid = 1'b1; req_op = op; req_tag = tag; req_data1 = d1; req_data2 = d2;
    req_rmode = 2'($urandom); req_region = 2'($urandom);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      r = req_ready;
      @(posedge clk); #1;
      if (r) ok = 1'b1;
    end
    req_valid = 1'b0;
    if (ok) begin
      acc_cyc = cyc;
      predict(op, tag, d1, d2);
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !busy && !res_valid) break;
      @(posedge clk); #1;
    end
    check("drain_complete", 64'(exp_q.size() == 0 && !busy), 64'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  initial begin
    bit ok;
    int n_acc, t, beg_snap;
    for (int k = 0; k < NU; k++) lat_cfg[k] = 3;

    // reset state
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_unit_beg", 64'(unit_beg), 64'd0);
    check("rst_unit_ack", 64'(unit_ack), 64'd0);
    check("rst_res_data", res_data, 64'd0);
    check("rst_res_err", 64'(res_err), 64'd0);
    check("rst_unit_data1", unit_data1, 64'd0);

    // single add with a 10-cycle unit
    lat_cfg[0] = 10; fix_en = 1'b1; fix_val = 64'h4008000000000000;
    push(3'b000, 4'd5, 64'h3FF0000000000000, 64'h4000000000000000, 20, ok);
    check("push_add", 64'(ok), 64'd1);
    t = acc_cyc;
    drain(100);
    // acc_cyc is the cycle after acceptance, so BEGIN (t+2) is one count later
    check("beg_latency", 64'(last_beg_cyc - t), 64'd1);
    fix_en = 1'b0;

    // unit selection: CORDIC, mult (ovf set), add/sub
    lat_cfg[0] = 2; lat_cfg[1] = 4; lat_cfg[2] = 6;
    push(3'b010, 4'd1, 64'h0123456789ABCDE0, 64'h1111, 20, ok);
    check("push_sel1", 64'(ok), 64'd1);
    push(3'b100, 4'd2, 64'h00000000DEADBEEF, 64'h2222, 20, ok);
    check("push_sel2", 64'(ok), 64'd1);
    push(3'b001, 4'd3, 64'h5555, 64'h3333, 20, ok);
    check("push_sel0", 64'(ok), 64'd1);
    drain(200);

    // timeout on a stuck unit, then a normal op
    lat_cfg[0] = 255; lat_cfg[1] = 3;
    push(3'b000, 4'd7, 64'h77, 64'h88, 20, ok);
    push(3'b011, 4'd8, 64'h99, 64'hAA, 20, ok);
    drain(200);

    // illegal unit index
    beg_snap = n_beg;
    push(3'b110, 4'd9, 64'h1234, 64'h5678, 20, ok);
    check("push_illegal", 64'(ok), 64'd1);
    drain(100);
    check("illegal_no_beg", 64'(n_beg - beg_snap), 64'd0);

    // back-pressure: 4 queued + 1 issued, 6th refused
    for (int k = 0; k < NU; k++) lat_cfg[k] = 2;
    rr_mode = 0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      push(3'(2 * (i % 3)), 4'(i + 1), 64'($urandom), 64'($urandom), (i < 5) ? 20 : 15, ok);
      if (ok) n_acc++;
    end
    check("full_accepted", 64'(n_acc), 64'd5);
    check("full_req_ready", 64'(req_ready), 64'd0);
    rr_mode = 1;
    drain(300);

    // randomized bursts (latencies straddle the watchdog limit)
    for (int b = 0; b < 6; b++) begin
      for (int k = 0; k < NU; k++) lat_cfg[k] = $urandom_range(1, 10);
      rr_mode = 2;
      for (int i = 0; i < 12; i++) begin
        push(3'($urandom), 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 200, ok);
        check("rand_push", 64'(ok), 64'd1);
        idle($urandom_range(0, 2));
      end
      drain(2000);
    end

    // reset during WAIT with two entries queued
    rr_mode = 1;
    lat_cfg[0] = 255;
    push(3'b000, 4'd1, 64'h10, 64'h20, 20, ok);
    push(3'b000, 4'd2, 64'h30, 64'h40, 20, ok);
    push(3'b001, 4'd3, 64'h50, 64'h60, 20, ok);
    idle(3);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("mid_rst_req_ready", 64'(req_ready), 64'd1);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_res_valid", 64'(res_valid), 64'd0);
    check("mid_rst_unit_beg", 64'(unit_beg), 64'd0);
    check("mid_rst_unit_ack", 64'(unit_ack), 64'd0);
    check("mid_rst_unit_data1", unit_data1, 64'd0);
    check("mid_rst_res_tag", 64'(res_tag), 64'd0);
    beg_snap = n_beg;
    idle(20);
    check("post_rst_quiet", 64'(n_beg - beg_snap), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
